// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: loader state encoding, byte framing constants and the instruction word type.
package mips_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE} state_e;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts bytes MSB-first into a 32-bit word and flags the fourth byte of each word.
module byte_packer
    import mips_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       byte_en_i,
    input  logic [7:0] byte_i,
    output logic [1:0] cnt_o,
    output word_t      word_o,
    output logic       word_valid_o
);
    logic [1:0] cnt_q, cnt_d;
    word_t      sh_q, sh_d;
    assign word_o       = {sh_q[23:0], byte_i};
    assign word_valid_o = byte_en_i && cnt_q == 2'(BYTES_PER_WORD - 1);
    assign cnt_o        = cnt_q;
    always_comb begin
        cnt_d = clr_i ? 2'd0 : byte_en_i ? cnt_q + 2'd1 : cnt_q;
        sh_d  = byte_en_i ? word_o : sh_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte image into instruction memory while holding the core in reset.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word verified before DONE.
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e LAST_NEXT = CSUM;
    word_t csum_q, csum_d;
`else
    localparam state_e LAST_NEXT = DONE;
`endif
    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    word_t             wdata_q, wdata_d;
    logic              done_q, done_d, error_q, error_d, core_reset_q;
    logic              byte_en, hdr_last, clr, word_valid, bad_n, last_word;
    logic [1:0]        cnt;
    word_t             word;
    assign in_ready   = state_q inside {HDR, DATA, CSUM};
    assign busy       = state_q != IDLE;
    assign byte_en    = in_valid && in_ready;
    assign hdr_last   = state_q == HDR && byte_en && cnt == 2'(HDR_BYTES - 1);
    assign clr        = state_q == IDLE || hdr_last;
    assign bad_n      = word[15:0] == 16'd0 || {17'd0, word[15:0]} > DEPTH;
    assign last_word  = 33'(idx_q) + 33'd1 == {17'd0, n_q};
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign error      = error_q;
    assign core_reset = core_reset_q;
    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (clr),
        .byte_en_i   (byte_en),
        .byte_i      (in_data),
        .cnt_o       (cnt),
        .word_o      (word),
        .word_valid_o(word_valid)
    );
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = HDR;
                done_d  = 1'b0;
                error_d = 1'b0;
                idx_d   = '0;
                addr_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            HDR: if (hdr_last) begin
                n_d     = word[15:0];
                state_d = bad_n ? IDLE : DATA;
                error_d = bad_n;
            end
            DATA: if (word_valid) begin
                we_d    = 1'b1;
                addr_d  = idx_q[ADDR_W-1:0];
                wdata_d = word;
                idx_d   = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d  = csum_q ^ word;
`endif
                state_d = last_word ? LAST_NEXT : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            // csum_q already holds the XOR of all N data words here
            CSUM: if (word_valid) begin
                state_d = word == csum_q ? DONE : IDLE;
                error_d = word != csum_q;
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_reset_q <= busy;
        end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) csum_q <= reset ? '0 : csum_d;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized load sessions checked against an expected-write list model.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    typedef struct {
        int          n;
        logic [31:0] flip;
        logic        exp_done;
        logic        exp_err;
        int          gap;
    } vec_t;
    logic              clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready, imem_we, core_reset, busy, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    int                nvec = 0, nfail = 0;
    logic [31:0]       words[$];
    logic [ADDR_W+31:0] wr_q[$];
    vec_t              tbl[$];
    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b, input int gapmax);
        int t = 0;
        repeat (gapmax > 0 ? $urandom_range(0, gapmax) : 0) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask
    task automatic chk_reset_outputs();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_core_reset", core_reset, 1);
    endtask
    // Model: a valid session writes words[i] at address i, in order, and nothing else.
    task automatic load(input int n, input logic [31:0] flip, input logic exp_done,
                        input logic exp_err, input int gapmax, input bit poke);
        logic [15:0] h  = 16'(n);
        logic [31:0] x  = '0;
        int          t  = 0;
        bit          ok = (n >= 1) && (n <= DEPTH);
        if (ok && words.size() != n) begin
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
        end
        wr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_flags", {done, error}, 2'b00);
        send(h[15:8], gapmax);
        send(h[7:0], gapmax);
        if (ok) begin
            chk("core_reset_busy", core_reset, 1);
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) begin
                    start = poke && (k == i);
                    send(words[i][31-8*k -: 8], gapmax);
                    start = 1'b0;
                end
                x ^= words[i];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            x ^= flip;
            for (int k = 0; k < 4; k++) send(x[31-8*k -: 8], gapmax);
`else
            chk("no_tail_consume", in_ready, 0);
`endif
        end
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("session_ends", busy, 0);
        chk("core_reset_hold", core_reset, 1);
        @(negedge clk);
        chk("core_reset_fall", core_reset, 0);
        chk("done", done, exp_done);
        chk("error", error, exp_err);
        tick(1);
        chk("write_count", 64'(wr_q.size()), ok ? 64'(n) : 64'd0);
        for (int i = 0; i < wr_q.size() && i < words.size(); i++)
            chk("write", wr_q[i], {i[ADDR_W-1:0], words[i]});
        words.delete();
    endtask
    initial begin
        logic [31:0] w0, w1;
        tick(3);
        chk_reset_outputs();
        reset = 1'b0;
        tick(1);
        chk("core_reset_release", core_reset, 0);
        words = '{32'h0025_0020, 32'h0025_0020};
        load(2, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick(3);
        chk("idle_not_ready", in_ready, 0);
        in_valid = 1'b0;
        load(2, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        tbl.push_back('{0, 32'h0, 1'b0, 1'b1, 0});
        tbl.push_back('{257, 32'h0, 1'b0, 1'b1, 1});
        tbl.push_back('{65535, 32'h0, 1'b0, 1'b1, 0});
        tbl.push_back('{1, 32'h0, 1'b1, 1'b0, 2});
        tbl.push_back('{3, 32'h0, 1'b1, 1'b0, 1});
        tbl.push_back('{DEPTH, 32'h0, 1'b1, 1'b0, 0});
`ifdef IMEM_LOADER_CHECKSUM_EN
        tbl.push_back('{2, 32'h0000_0100, 1'b0, 1'b1, 1});
`endif
        foreach (tbl[v]) load(tbl[v].n, tbl[v].flip, tbl[v].exp_done, tbl[v].exp_err, tbl[v].gap, 1'b0);
        load(3, 32'h0, 1'b1, 1'b0, 1, 1'b1);
        w0 = $urandom;
        w1 = $urandom;
        wr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(8'h00, 0);
        send(8'h02, 0);
        for (int k = 0; k < 4; k++) send(w0[31-8*k -: 8], 0);
        for (int k = 0; k < 2; k++) send(w1[31-8*k -: 8], 0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_core_reset_release", core_reset, 0);
        tick(2);
        chk("abort_write_count", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) chk("abort_write0", wr_q[0], {8'h00, w0});
        load(1, 32'h0, 1'b1, 1'b0, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        words = '{32'h0025_0020};
        load(1, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);
        words = '{32'h0025_0020};
        load(1, 32'h0, 1'b1, 1'b0, 0, 1'b0);
`endif
        for (int r = 0; r < 6; r++)
            load($urandom_range(1, 12), 32'h0, 1'b1, 1'b0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        for (int r = 0; r < 2; r++)
            load($urandom_range(DEPTH + 1, 65535), 32'h0, 1'b0, 1'b1, 1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
        $fatal(1);
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width (DEPTH = 2**ADDR_W words).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle pulse that begins a load session.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a byte is offered on in_data.
REQ-006 The block SHALL have port in_data, input, 8, the load byte stream.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 The block SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, ADDR_W, the word address being written.
REQ-010 The block SHALL have port imem_wdata, output, 32, the instruction word being written.
REQ-011 The block SHALL have port core_reset, output, 1, which holds the MIPS core in reset.
REQ-012 The block SHALL have port busy, output, 1, which is high whenever state != IDLE.
REQ-013 The block SHALL have port done, output, 1, a sticky flag for a successful load.
REQ-014 The block SHALL have port error, output, 1, a sticky flag for a failed load.

Function
REQ-015 The loader SHALL implement states IDLE, HDR, DATA, CSUM and DONE.
REQ-016 A byte SHALL transfer only on a cycle where in_valid and in_ready are both high.
REQ-017 In IDLE, in_ready SHALL be 0; a start pulse SHALL clear done and error, zero the address and byte counters, and move to HDR.
REQ-018 In HDR, in_ready SHALL be 1 and the loader SHALL accept two bytes, MSB first, into a 16-bit word count N.
REQ-019 After the second header byte, if N == 0 or N > DEPTH the loader SHALL set error and return to IDLE; otherwise it SHALL move to DATA.
REQ-020 In DATA, in_ready SHALL be 1 and the loader SHALL accept bytes MSB first, four per word (first byte to bits 31:24).
REQ-021 In the cycle after the fourth byte transfers, imem_we SHALL be 1 for exactly one cycle, with imem_wdata = the assembled word and imem_addr = the current word index.
REQ-022 The word index SHALL start at 0 and increment after each write, with no wrap-around, since N <= DEPTH.
REQ-023 After word N-1 is written, the loader SHALL go to CSUM if REQ-031 applies, otherwise to DONE.
REQ-024 DONE SHALL last one cycle, set done, and return to IDLE.
REQ-025 start SHALL be ignored in any state other than IDLE.
REQ-026 core_reset SHALL equal reset OR busy, registered, with no combinational path from start.
REQ-027 Bytes offered while in_ready == 0 SHALL NOT be consumed, and in_valid in IDLE SHALL have no effect.

Reset
REQ-028 On reset the loader SHALL enter IDLE and SHALL drive in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0 and core_reset=1 (core_reset=0 in the cycle after reset deasserts).
REQ-029 Reset during HDR, DATA or CSUM SHALL abort the session, and SHALL complete no partial word write.

Configuration
REQ-030 The block SHALL use a macro named IMEM_LOADER_CHECKSUM_EN.
REQ-031 When IMEM_LOADER_CHECKSUM_EN is defined, CSUM SHALL accept one trailing 4-byte word; if it equals the XOR of all N data words the loader SHALL go to DONE, otherwise it SHALL set error and return to IDLE without setting done.
REQ-032 When IMEM_LOADER_CHECKSUM_EN is not defined, the CSUM state and the XOR accumulator SHALL NOT be built, and the byte after the last word SHALL NOT be consumed.

Structure
REQ-033 Package mips_loader_pkg SHALL hold the state enumeration, HDR_BYTES=2, BYTES_PER_WORD=4 and the 32-bit word type.
REQ-034 Sub-module byte_packer SHALL hold the 2-bit byte counter and 32-bit shift register, and SHALL emit word_valid on the fourth byte.

Verification
REQ-035 Stimulus start, bytes 00 02 00 25 00 20 00 25 00 20 -> two imem_we pulses writing addr0=00250020 and addr1=00250020, done=1, core_reset falling after DONE.
REQ-036 Stimulus header 00 00 -> error=1, state IDLE, no imem_we, done=0.
REQ-037 Stimulus header 01 01 (257) with ADDR_W=8 -> error=1, no writes.
REQ-038 Stimulus start pulses issued mid-DATA -> ignored, and addresses continue 0,1,2 unchanged.
REQ-039 Stimulus reset after 2 bytes of word 1 -> IDLE, no write at addr1; a new start then loads from addr0.
REQ-040 With IMEM_LOADER_CHECKSUM_EN, N=1, word 00250020, trailer 00250021 -> error=1, done=0; with trailer 00250020 -> done=1.
